// File: rtl/stream_upsizer_if.sv
// stream_upsizer_if: narrow input stream and packed wide output stream of the upsizer
interface stream_upsizer_if #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
);
    localparam int DATA_WIDTH = IN_WIDTH * RATIO;

    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [RATIO-1:0]      out_keep;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    // Environment side: feeds narrow beats and sinks packed words
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );

    // Upsizer side
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );
endinterface

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO little-endian IN_WIDTH-bit beats into one word with keep/last
module stream_upsizer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input logic              clk,
    input logic              rst_n,
    stream_upsizer_if.slave  bus
);
    localparam int DATA_WIDTH = IN_WIDTH * RATIO;
    localparam int CW         = $clog2(RATIO);

    typedef enum logic {FILL, FULL} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt, lane;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic [RATIO-1:0]      keep_q, keep_nxt;
    logic                  last_q, last_nxt;
    logic                  in_fire, out_fire;

    // A held word blocks new beats unless it drains in the same cycle
    assign bus.in_ready  = rst_n && (state == FILL || bus.out_ready);
    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_keep  = keep_q;
    assign bus.out_last  = last_q;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    // Next state: drain clears the buffer first so a same-cycle beat lands in lane 0
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        keep_nxt  = keep_q;
        last_nxt  = last_q;
        lane      = (state == FULL) ? '0 : cnt;
        if (out_fire) begin
            state_nxt = FILL;
            cnt_nxt   = '0;
            data_nxt  = '0;
            keep_nxt  = '0;
            last_nxt  = 1'b0;
        end
        if (in_fire) begin
            data_nxt[lane*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            keep_nxt[lane] = 1'b1;
            last_nxt       = bus.in_last;
            state_nxt      = (lane == CW'(RATIO - 1) || bus.in_last) ? FULL : FILL;
            cnt_nxt        = (lane == CW'(RATIO - 1) || bus.in_last) ? '0 : lane + 1'b1;
        end
    end

    // State and word buffer; reset discards any partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            cnt    <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_nxt;
            keep_q <= keep_nxt;
            last_q <= last_nxt;
        end
    end
endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: directed scenarios plus random traffic against a queue-based packing model
module tb_stream_upsizer;
    localparam int IN_WIDTH = 8;
    localparam int RATIO    = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   passed = 0;
    int   total = 0;

    logic [7:0] part[$];
    word_t      exp_q[$];
    word_t      w, prev;
    logic       prev_hold = 1'b0;
    logic       exp_v;

    always #5 clk = ~clk;

    stream_upsizer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) bus();

    stream_upsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Monitor: every beat/word handshake is replayed into a list-of-beats model
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            part.delete();
            exp_q.delete();
            prev_hold = 1'b0;
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0)
                $display("FAIL mon_reset: out_valid=%b in_ready=%b, want 0/0", bus.out_valid, bus.in_ready);
            else passed++;
        end else begin
            exp_v = exp_q.size() != 0;
            total++;
            if (bus.out_valid !== exp_v)
                $display("FAIL mon_valid: out_valid=%b, want %b", bus.out_valid, exp_v);
            else passed++;
            total++;
            if (bus.in_ready !== (!exp_v || bus.out_ready))
                $display("FAIL mon_ready: in_ready=%b, want %b", bus.in_ready, !exp_v || bus.out_ready);
            else passed++;
            if (prev_hold) begin
                total++;
                if ({bus.out_data, bus.out_keep, bus.out_last} !== prev)
                    $display("FAIL mon_stable: word %h/%b/%b, want %h/%b/%b", bus.out_data, bus.out_keep,
                             bus.out_last, prev.d, prev.k, prev.l);
                else passed++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev = {bus.out_data, bus.out_keep, bus.out_last};
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                total++;
                if ({bus.out_data, bus.out_keep, bus.out_last} !== w)
                    $display("FAIL mon_word: got %h/%b/%b, want %h/%b/%b", bus.out_data, bus.out_keep,
                             bus.out_last, w.d, w.k, w.l);
                else passed++;
            end
            if (bus.in_valid && bus.in_ready) begin
                part.push_back(bus.in_data);
                if (part.size() == RATIO || bus.in_last) begin
                    w.d = '0;
                    foreach (part[i]) w.d = w.d | (32'(part[i]) << (8 * i));
                    w.k = 4'((1 << part.size()) - 1);
                    w.l = bus.in_last;
                    exp_q.push_back(w);
                    part.delete();
                end
            end
        end
    end

    ap_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid && !bus.out_ready |=> $stable({bus.out_data, bus.out_keep, bus.out_last}))
        else begin total++; $display("FAIL assert_stable"); end
    ap_reset: assert property (@(posedge clk) !rst_n |=> !bus.out_valid)
        else begin total++; $display("FAIL assert_reset_valid"); end
    ap_keep: assert property (@(posedge clk) disable iff (!rst_n) bus.out_valid |-> bus.out_keep != 0)
        else begin total++; $display("FAIL assert_keep_nonzero"); end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat until accepted; returns at edge+1 of the accepting edge
    task automatic send(input logic [7:0] d, input logic l, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!ok && waits < 50) begin
            #1;
            ok = (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (!ok) waits++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
        total++;
        if (!ok) $display("FAIL send_timeout: beat %h not accepted within 50 cycles", d);
        else passed++;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else passed++;
        total++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
        total++;
        if (bus.out_data !== 32'h0) $display("FAIL reset_data: got %h want 0", bus.out_data); else passed++;
        total++;
        if (bus.out_keep !== 4'h0) $display("FAIL reset_keep: got %b want 0", bus.out_keep); else passed++;
        total++;
        if (bus.out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", bus.out_last); else passed++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_full_word();
        int wt;
        int wsum;
        wsum = 0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), i == 4, wt);
            wsum += wt;
        end
        total++;
        if (wsum !== 0) $display("FAIL full_stall: %0d wait cycles, want 0", wsum); else passed++;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201 || bus.out_keep !== 4'hF || bus.out_last !== 1'b1)
            $display("FAIL full_word: got v=%b %h/%b/%b want 1 04030201/1111/1", bus.out_valid, bus.out_data,
                     bus.out_keep, bus.out_last);
        else passed++;
        tick();
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL full_drain: out_valid=%b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_partial();
        int wt;
        send(8'hAA, 1'b0, wt);
        send(8'hBB, 1'b1, wt);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000BBAA || bus.out_keep !== 4'b0011 || bus.out_last !== 1'b1)
            $display("FAIL partial_word: got v=%b %h/%b/%b want 1 0000bbaa/0011/1", bus.out_valid, bus.out_data,
                     bus.out_keep, bus.out_last);
        else passed++;
        send(8'hCC, 1'b1, wt);
        total++;
        if (wt !== 0) $display("FAIL partial_overlap_wait: %0d wait cycles want 0", wt); else passed++;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h000000CC || bus.out_keep !== 4'b0001 || bus.out_last !== 1'b1)
            $display("FAIL partial_lane0: got v=%b %h/%b/%b want 1 000000cc/0001/1", bus.out_valid, bus.out_data,
                     bus.out_keep, bus.out_last);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int wt;
        bus.out_ready = 1'b0;
        send(8'h11, 1'b0, wt);
        send(8'h22, 1'b0, wt);
        send(8'h33, 1'b0, wt);
        send(8'h44, 1'b1, wt);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        bus.in_last  = 1'b0;
        repeat (3) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); else passed++;
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211 || bus.out_keep !== 4'hF || bus.out_last !== 1'b1)
                $display("FAIL bp_hold: got v=%b %h/%b/%b want 1 44332211/1111/1", bus.out_valid, bus.out_data,
                         bus.out_keep, bus.out_last);
            else passed++;
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); else passed++;
        tick();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_after_drain: out_valid=%b want 0", bus.out_valid); else passed++;
        send(8'h66, 1'b0, wt);
        send(8'h77, 1'b0, wt);
        send(8'h88, 1'b1, wt);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h88776655 || bus.out_keep !== 4'hF || bus.out_last !== 1'b1)
            $display("FAIL bp_next_word: got v=%b %h/%b/%b want 1 88776655/1111/1", bus.out_valid, bus.out_data,
                     bus.out_keep, bus.out_last);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[8];
        int wt;
        int cyc;
        int v_at[2];
        int nv;
        cyc = 0;
        nv = 0;
        bus.out_ready = 1'b1;
        foreach (b[i]) b[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            send(b[i], 1'b0, wt);
            cyc += wt + 1;
            total++;
            if (wt !== 0) $display("FAIL b2b_stall: beat %0d waited %0d cycles want 0", i, wt); else passed++;
            total++;
            if (bus.out_valid !== (i % 4 == 3))
                $display("FAIL b2b_valid: beat %0d out_valid=%b want %b", i, bus.out_valid, i % 4 == 3);
            else passed++;
            if (bus.out_valid === 1'b1 && nv < 2) begin
                v_at[nv] = cyc;
                total++;
                if (bus.out_data !== {b[i], b[i-1], b[i-2], b[i-3]} || bus.out_keep !== 4'hF || bus.out_last !== 1'b0)
                    $display("FAIL b2b_word: got %h/%b/%b want %h/1111/0", bus.out_data, bus.out_keep, bus.out_last,
                             {b[i], b[i-1], b[i-2], b[i-3]});
                else passed++;
                nv++;
            end
        end
        total++;
        if (nv !== 2 || v_at[1] - v_at[0] !== 4)
            $display("FAIL b2b_spacing: words=%0d gap=%0d want 2 words gap 4", nv, v_at[1] - v_at[0]);
        else passed++;
        tick();
    endtask

    task automatic test_reset_midword();
        int wt;
        bus.out_ready = 1'b1;
        send(8'($urandom), 1'b0, wt);
        send(8'($urandom), 1'b0, wt);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_keep !== 4'h0 || bus.out_data !== 32'h0)
            $display("FAIL midreset_state: v=%b rdy=%b keep=%b data=%h want 0/0/0/0", bus.out_valid, bus.in_ready,
                     bus.out_keep, bus.out_data);
        else passed++;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) send(8'hA0 + 8'(i), 1'b0, wt);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA4A3A2A1 || bus.out_keep !== 4'hF || bus.out_last !== 1'b0)
            $display("FAIL midreset_word: got v=%b %h/%b/%b want 1 a4a3a2a1/1111/0", bus.out_valid, bus.out_data,
                     bus.out_keep, bus.out_last);
        else passed++;
        tick();
    endtask

    task automatic test_random();
        int wt;
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            bus.in_last   = ($urandom_range(0, 4) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        send(8'h5A, 1'b1, wt);
        tick();
        tick();
        total++;
        if (exp_q.size() !== 0 || part.size() !== 0)
            $display("FAIL random_residue: %0d words and %0d beats outstanding want 0/0", exp_q.size(), part.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
